id_ex_stage: RTL and testbench

Decode/execute boundary register for the RV32I core. It takes a fetched instruction plus register-file read data, decodes the instruction into the 4-bit ALU control code and the ALU A/B operands, and holds them in a valid/ready pipeline register. Its outputs drive the `alu` block's `A`, `B` and `Control` inputs directly. Its sideband fields (`rd`, write-enable, memory strobes) travel on to the memory stage.

---
 rtl/id_ex_stage.sv | 253 +++++++++++++++++++++++++
 tb/tb_id_ex_stage.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// Decodes an RV32I instruction into ALU control/operands and holds them in a valid/ready pipe register.
// Latency: 1 cycle from accept edge to ex_* outputs; 1 instruction/cycle throughput.
// Backpressure: in_ready drops while a live entry is held and ex_ready is low; flush always reopens it.
module id_ex_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            flush,
    input  logic            ex_ready,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_A,
    output logic [XLEN-1:0] ex_B,
    output logic [3:0]      ex_control,
    output logic [4:0]      ex_rd,
    output logic            ex_we,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic [XLEN-1:0] ex_store_data,
    output logic            illegal_instr
);

    localparam logic [3:0] C_LUI  = 4'd0;
    localparam logic [3:0] C_LW   = 4'd1;
    localparam logic [3:0] C_ADD  = 4'd2;
    localparam logic [3:0] C_XOR  = 4'd3;
    localparam logic [3:0] C_OR   = 4'd4;
    localparam logic [3:0] C_AND  = 4'd5;
    localparam logic [3:0] C_SLL  = 4'd6;
    localparam logic [3:0] C_SRL  = 4'd7;
    localparam logic [3:0] C_SRA  = 4'd8;
    localparam logic [3:0] C_SUB  = 4'd9;
    localparam logic [3:0] C_SLT  = 4'd10;
    localparam logic [3:0] C_SLTU = 4'd11;
    localparam logic [3:0] C_NOP  = 4'd12;

    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Instruction fields and immediates
    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_u;
    logic [31:0] shamt;

    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];
    assign imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_u  = {instr[31:12], 12'b0};
    assign shamt  = {27'b0, instr[24:20]};

    // Decoded values, before registering
    logic [3:0]      dec_ctrl;
    logic [XLEN-1:0] dec_a;
    logic [XLEN-1:0] dec_b;
    logic            dec_wb;
    logic            dec_mrd;
    logic            dec_mwr;
    logic            dec_illegal;

    // Pipeline registers
    logic            ex_valid_q, ex_valid_d;
    logic [XLEN-1:0] ex_a_q, ex_a_d;
    logic [XLEN-1:0] ex_b_q, ex_b_d;
    logic [3:0]      ex_control_q, ex_control_d;
    logic [4:0]      ex_rd_q, ex_rd_d;
    logic            ex_we_q, ex_we_d;
    logic            ex_mem_read_q, ex_mem_read_d;
    logic            ex_mem_write_q, ex_mem_write_d;
    logic [XLEN-1:0] ex_store_data_q, ex_store_data_d;
    logic            illegal_q, illegal_d;

    logic accept;

    // Flush opens the stage so an upstream stall cannot outlive the kill
    assign in_ready = !ex_valid_q || ex_ready || flush;
    assign accept   = in_valid && in_ready && !flush;

    // Instruction decode: ALU code, operands, strobes, legality
    always_comb begin
        dec_ctrl    = C_NOP;
        dec_a       = rs1_data;
        dec_b       = rs2_data;
        dec_wb      = 1'b0;
        dec_mrd     = 1'b0;
        dec_mwr     = 1'b0;
        dec_illegal = 1'b0;
        unique case (opcode)
            OP_OP: begin
                dec_wb = 1'b1;
                if (f7 == F7_BASE) begin
                    unique case (f3)
                        3'b000: dec_ctrl = C_ADD;
                        3'b001: dec_ctrl = C_SLL;
                        3'b010: dec_ctrl = C_SLT;
                        3'b011: dec_ctrl = C_SLTU;
                        3'b100: dec_ctrl = C_XOR;
                        3'b101: dec_ctrl = C_SRL;
                        3'b110: dec_ctrl = C_OR;
                        default: dec_ctrl = C_AND;
                    endcase
                end else if (f7 == F7_ALT && f3 == 3'b000) begin
                    dec_ctrl = C_SUB;
                end else if (f7 == F7_ALT && f3 == 3'b101) begin
                    dec_ctrl = C_SRA;
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            OP_IMM: begin
                dec_wb = 1'b1;
                dec_b  = imm_i;
                unique case (f3)
                    3'b000: dec_ctrl = C_ADD;
                    3'b010: dec_ctrl = C_SLT;
                    3'b011: dec_ctrl = C_SLTU;
                    3'b100: dec_ctrl = C_XOR;
                    3'b110: dec_ctrl = C_OR;
                    3'b111: dec_ctrl = C_AND;
                    3'b001: begin
                        dec_b = shamt;
                        if (f7 == F7_BASE) dec_ctrl = C_SLL;
                        else               dec_illegal = 1'b1;
                    end
                    default: begin
                        dec_b = shamt;
                        if (f7 == F7_BASE)     dec_ctrl = C_SRL;
                        else if (f7 == F7_ALT) dec_ctrl = C_SRA;
                        else                   dec_illegal = 1'b1;
                    end
                endcase
            end
            OP_LUI: begin
                dec_wb   = 1'b1;
                dec_ctrl = C_LUI;
                dec_a    = '0;
                dec_b    = imm_u;
            end
            OP_AUIPC: begin
                dec_wb   = 1'b1;
                dec_ctrl = C_ADD;
                dec_a    = pc;
                dec_b    = imm_u;
            end
            OP_LOAD: begin
                dec_wb   = 1'b1;
                dec_ctrl = C_LW;
                dec_b    = imm_i;
                dec_mrd  = 1'b1;
                dec_illegal = (f3 != 3'b010);
            end
            OP_STORE: begin
                dec_ctrl = C_ADD;
                dec_b    = imm_s;
                dec_mwr  = 1'b1;
                dec_illegal = (f3 != 3'b010);
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    // Next-state: flush > accept > drain > hold; illegal flag is a single-cycle pulse
    always_comb begin
        ex_valid_d      = ex_valid_q;
        ex_a_d          = ex_a_q;
        ex_b_d          = ex_b_q;
        ex_control_d    = ex_control_q;
        ex_rd_d         = ex_rd_q;
        ex_we_d         = ex_we_q;
        ex_mem_read_d   = ex_mem_read_q;
        ex_mem_write_d  = ex_mem_write_q;
        ex_store_data_d = ex_store_data_q;
        illegal_d       = 1'b0;
        if (flush || (accept && dec_illegal) || (!accept && ex_ready)) begin
            // Bubble: nothing live, so no side effects may leak downstream
            ex_valid_d     = 1'b0;
            ex_control_d   = C_NOP;
            ex_we_d        = 1'b0;
            ex_mem_read_d  = 1'b0;
            ex_mem_write_d = 1'b0;
            illegal_d      = !flush && accept && dec_illegal;
        end else if (accept) begin
            ex_valid_d      = 1'b1;
            ex_a_d          = dec_a;
            ex_b_d          = dec_b;
            ex_control_d    = dec_ctrl;
            ex_rd_d         = rd;
            ex_we_d         = dec_wb && (rd != 5'd0);
            ex_mem_read_d   = dec_mrd;
            ex_mem_write_d  = dec_mwr;
            ex_store_data_d = rs2_data;
        end
    end

    // Stage register with asynchronous reset to the bubble state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q      <= 1'b0;
            ex_a_q          <= '0;
            ex_b_q          <= '0;
            ex_control_q    <= C_NOP;
            ex_rd_q         <= '0;
            ex_we_q         <= 1'b0;
            ex_mem_read_q   <= 1'b0;
            ex_mem_write_q  <= 1'b0;
            ex_store_data_q <= '0;
            illegal_q       <= 1'b0;
        end else begin
            ex_valid_q      <= ex_valid_d;
            ex_a_q          <= ex_a_d;
            ex_b_q          <= ex_b_d;
            ex_control_q    <= ex_control_d;
            ex_rd_q         <= ex_rd_d;
            ex_we_q         <= ex_we_d;
            ex_mem_read_q   <= ex_mem_read_d;
            ex_mem_write_q  <= ex_mem_write_d;
            ex_store_data_q <= ex_store_data_d;
            illegal_q       <= illegal_d;
        end
    end

    assign ex_valid      = ex_valid_q;
    assign ex_A          = ex_a_q;
    assign ex_B          = ex_b_q;
    assign ex_control    = ex_control_q;
    assign ex_rd         = ex_rd_q;
    assign ex_we         = ex_we_q;
    assign ex_mem_read   = ex_mem_read_q;
    assign ex_mem_write  = ex_mem_write_q;
    assign ex_store_data = ex_store_data_q;
    assign illegal_instr = illegal_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: decode vectors, backpressure, flush, illegal, async reset.
// Inputs change 1 time unit after a rising edge; outputs are checked at that same point.
// Downstream ready is driven directly by the bench to create hold windows.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        flush;
    logic        ex_ready;
    logic        ex_valid;
    logic [31:0] ex_A;
    logic [31:0] ex_B;
    logic [3:0]  ex_control;
    logic [4:0]  ex_rd;
    logic        ex_we;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic [31:0] ex_store_data;
    logic        illegal_instr;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .instr         (instr),
        .pc            (pc),
        .rs1_data      (rs1_data),
        .rs2_data      (rs2_data),
        .flush         (flush),
        .ex_ready      (ex_ready),
        .ex_valid      (ex_valid),
        .ex_A          (ex_A),
        .ex_B          (ex_B),
        .ex_control    (ex_control),
        .ex_rd         (ex_rd),
        .ex_we         (ex_we),
        .ex_mem_read   (ex_mem_read),
        .ex_mem_write  (ex_mem_write),
        .ex_store_data (ex_store_data),
        .illegal_instr (illegal_instr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] i, input logic [31:0] p,
                         input logic [31:0] a, input logic [31:0] b);
        instr    = i;
        pc       = p;
        rs1_data = a;
        rs2_data = b;
        in_valid = 1'b1;
    endtask

    // Present one instruction for a single accept edge, then go idle
    task automatic issue(input logic [31:0] i, input logic [31:0] p,
                         input logic [31:0] a, input logic [31:0] b);
        drive(i, p, a, b);
        step();
        in_valid = 1'b0;
    endtask

    task automatic chk_bubble(input string tag);
        chk({tag, "_vld"}, {31'b0, ex_valid}, 32'd0);
        chk({tag, "_ctl"}, {28'b0, ex_control}, 32'd12);
        chk({tag, "_side"}, {29'b0, ex_we, ex_mem_read, ex_mem_write}, 32'd0);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; ex_ready = 1'b1;
        instr = 32'h0; pc = 32'h0; rs1_data = 32'h0; rs2_data = 32'h0;
        #12;
        chk_bubble("rst");
        chk("rst_A", ex_A, 32'h0);
        chk("rst_rdy", {31'b0, in_ready}, 32'd1);
        chk("rst_ill", {31'b0, illegal_instr}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // add x3,x1,x2
        issue(32'h002081B3, 32'h0, 32'hF00000A2, 32'h2);
        chk("add_vld", {31'b0, ex_valid}, 32'd1);
        chk("add_ctl", {28'b0, ex_control}, 32'd2);
        chk("add_A", ex_A, 32'hF00000A2);
        chk("add_B", ex_B, 32'h2);
        chk("add_rd", {27'b0, ex_rd}, 32'd3);
        chk("add_we", {31'b0, ex_we}, 32'd1);
        // sub x3,x1,x2 back to back
        issue(32'h402081B3, 32'h0, 32'h10, 32'h3);
        chk("sub_ctl", {28'b0, ex_control}, 32'd9);
        // srai x5,x1,2
        issue(32'h4020D293, 32'h0, 32'h80000000, 32'h7);
        chk("srai_ctl", {28'b0, ex_control}, 32'd8);
        chk("srai_B", ex_B, 32'h00000002);
        chk("srai_rd", {27'b0, ex_rd}, 32'd5);
        // lui x1,0xF0000
        issue(32'hF00000B7, 32'h0, 32'h1234, 32'h0);
        chk("lui_ctl", {28'b0, ex_control}, 32'd0);
        chk("lui_A", ex_A, 32'h0);
        chk("lui_B", ex_B, 32'hF0000000);
        // auipc x2,0x1 at pc 0x100
        issue(32'h00001117, 32'h100, 32'h55, 32'h0);
        chk("auipc_ctl", {28'b0, ex_control}, 32'd2);
        chk("auipc_A", ex_A, 32'h100);
        chk("auipc_B", ex_B, 32'h1000);
        // lw x4,-4(x2)
        issue(32'hFFC12203, 32'h0, 32'h2000, 32'h0);
        chk("lw_ctl", {28'b0, ex_control}, 32'd1);
        chk("lw_B", ex_B, 32'hFFFFFFFC);
        chk("lw_A", ex_A, 32'h2000);
        chk("lw_strb", {29'b0, ex_we, ex_mem_read, ex_mem_write}, 32'b110);
        // sw x5,8(x2)
        issue(32'h00512423, 32'h0, 32'h3000, 32'hCAFEF00D);
        chk("sw_ctl", {28'b0, ex_control}, 32'd2);
        chk("sw_B", ex_B, 32'h8);
        chk("sw_strb", {29'b0, ex_we, ex_mem_read, ex_mem_write}, 32'b001);
        chk("sw_sd", ex_store_data, 32'hCAFEF00D);
        // idle cycle drains to a bubble
        step();
        chk_bubble("drain");

        // backpressure: held add, next sub waits 3 cycles
        ex_ready = 1'b0;
        issue(32'h002081B3, 32'h0, 32'hAAAA0000, 32'h11);
        drive(32'h402081B3, 32'h0, 32'h77, 32'h22);
        for (int k = 0; k < 3; k++) begin
            chk("bp_rdy", {31'b0, in_ready}, 32'd0);
            chk("bp_ctl", {28'b0, ex_control}, 32'd2);
            chk("bp_A", ex_A, 32'hAAAA0000);
            step();
        end
        ex_ready = 1'b1;
        #1;
        chk("bp_rdy_rel", {31'b0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        chk("bp_next_ctl", {28'b0, ex_control}, 32'd9);
        chk("bp_next_A", ex_A, 32'h77);
        step();
        chk_bubble("bp_nodup");

        // flush during hold with an incoming instruction
        ex_ready = 1'b0;
        issue(32'h002081B3, 32'h0, 32'h1, 32'h1);
        drive(32'h402081B3, 32'h0, 32'h9, 32'h9);
        flush = 1'b1;
        #1;
        chk("fl_rdy", {31'b0, in_ready}, 32'd1);
        step();
        flush = 1'b0; in_valid = 1'b0; ex_ready = 1'b1;
        chk_bubble("fl");
        chk("fl_ill", {31'b0, illegal_instr}, 32'd0);
        step();
        chk_bubble("fl_gone");

        // illegal opcode
        issue(32'h0000007F, 32'h0, 32'h0, 32'h0);
        chk("ill_pulse", {31'b0, illegal_instr}, 32'd1);
        chk_bubble("ill");
        step();
        chk("ill_end", {31'b0, illegal_instr}, 32'd0);
        // bad funct7 on slli is illegal
        issue(32'h40209093, 32'h0, 32'h0, 32'h0);
        chk("slli_bad", {31'b0, illegal_instr}, 32'd1);
        step();

        // addi x0,x1,5
        issue(32'h00508013, 32'h0, 32'h10, 32'h0);
        chk("x0_vld", {31'b0, ex_valid}, 32'd1);
        chk("x0_we", {31'b0, ex_we}, 32'd0);
        chk("x0_B", ex_B, 32'h5);

        // async reset mid-hold
        ex_ready = 1'b0;
        issue(32'h002081B3, 32'h0, 32'h5, 32'h6);
        chk("ar_pre", {31'b0, ex_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_bubble("ar");
        chk("ar_A", ex_A, 32'h0);
        chk("ar_rdy", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        ex_ready = 1'b1;
        step();
        chk_bubble("ar_after");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
